// File: rtl/trace_capture.sv
// Per-cycle PC/instruction/writeback recorder: one-shot or ring buffer, oldest-first pop port.
// Records are poppable one cycle after capture; rd_vld/data follow rd_req by one cycle; no stall, overflow flags ring overwrite.
module trace_capture #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] CYCLE_LIMIT = 32'd500
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   cap_en,
  input  logic                   mode,
  input  logic                   filt_wb,
  input  logic [PC_W-1:0]        pc,
  input  logic [INST_W-1:0]      inst,
  input  logic                   rf_we,
  input  logic [4:0]             rf_waddr,
  input  logic [DATA_W-1:0]      rf_wdata,
  input  logic                   rd_req,
  output logic                   rd_vld,
  output logic [PC_W-1:0]        rd_pc,
  output logic [INST_W-1:0]      rd_inst,
  output logic                   rd_we,
  output logic [4:0]             rd_waddr,
  output logic [DATA_W-1:0]      rd_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   done,
  output logic [31:0]            cycle_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   cyc_nxt;
  logic          cap_now, wr_en, pop, cnt_inc, cnt_dec;
  rec_t          wr_rec, rd_rec;
  rec_t          mem [DEPTH];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign done  = (state == S_DONE);

  assign wr_rec = '{pc: pc, inst: inst, we: rf_we, waddr: rf_waddr, wdata: rf_wdata};

  always_comb begin
    state_nxt = state;
    cap_now   = 1'b0;
    wr_en     = 1'b0;
    cyc_nxt   = cycle_cnt;
    pop       = rd_req && !empty;
    case (state)
      S_IDLE, S_CAPTURE: begin
        if (cap_en) begin
          cap_now   = 1'b1;
          state_nxt = S_CAPTURE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (cap_now) begin
      cyc_nxt = cycle_cnt + 32'd1;
      // one-shot mode never writes into a full buffer; ring mode overwrites
      wr_en   = (!filt_wb || rf_we) && (mode || !full);
      if (cyc_nxt == CYCLE_LIMIT) state_nxt = S_DONE;
      if (!mode && (full || (wr_en && !pop && count == LAST_CNT))) state_nxt = S_DONE;
    end
  end

  // A write into a full ring either overwrites (no pop) or refills the slot a pop frees.
  assign cnt_inc = wr_en && !full;
  assign cnt_dec = pop && !(wr_en && full);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cycle_cnt <= '0;
      rd_vld    <= 1'b0;
      rd_rec    <= '0;
    end else if (clear) begin
      state     <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cycle_cnt <= '0;
      rd_vld    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cyc_nxt;
      rd_vld    <= pop;
      if (pop) rd_rec <= mem[rptr];
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop || (wr_en && full)) rptr <= rptr + 1'b1;
      if (wr_en && full && !pop) overflow <= 1'b1;
      if (cnt_inc && !cnt_dec) count <= count + 1'b1;
      else if (cnt_dec && !cnt_inc) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset && !clear && wr_en) mem[wptr] <= wr_rec;
  end

  assign rd_pc    = rd_rec.pc;
  assign rd_inst  = rd_rec.inst;
  assign rd_we    = rd_rec.we;
  assign rd_waddr = rd_rec.waddr;
  assign rd_wdata = rd_rec.wdata;

endmodule

// File: tb/tb_trace_capture.sv
// Randomised bench for trace_capture: queue-based reference model plus a pop scoreboard.
module tb_trace_capture;

  localparam int DEPTH = 64;
  localparam int LIMIT = 500;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  logic        clk_in = 1'b0;
  logic        reset, clear, cap_en, mode, filt_wb, rf_we, rd_req;
  logic [31:0] pc, inst, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rd_vld, rd_we, empty, full, overflow, done;
  logic [31:0] rd_pc, rd_inst, rd_wdata, cycle_cnt;
  logic [4:0]  rd_waddr;
  logic [6:0]  count;

  int   total = 0;
  int   bad   = 0;
  rec_t m_q[$];
  rec_t exp_q[$];
  rec_t seen_q[$];
  int   m_state;
  logic [31:0] m_cyc;
  logic m_ovf;
  rec_t mon_e;
  logic [31:0] first_pc;

  trace_capture dut (
    .clk_in(clk_in), .reset(reset), .clear(clear), .cap_en(cap_en), .mode(mode),
    .filt_wb(filt_wb), .pc(pc), .inst(inst), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rd_req(rd_req), .rd_vld(rd_vld), .rd_pc(rd_pc),
    .rd_inst(rd_inst), .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .count(count), .empty(empty), .full(full), .overflow(overflow), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every presented pop is matched against the oldest expected record.
  always @(posedge clk_in) begin
    #1;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 64'(rd_vld), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_pc", 64'(rd_pc), 64'(mon_e.pc));
        chk("rd_inst", 64'(rd_inst), 64'(mon_e.inst));
        chk("rd_we", 64'(rd_we), 64'(mon_e.we));
        chk("rd_waddr", 64'(rd_waddr), 64'(mon_e.waddr));
        chk("rd_wdata", 64'(rd_wdata), 64'(mon_e.wdata));
        seen_q.push_back('{pc: rd_pc, inst: rd_inst, we: rd_we, waddr: rd_waddr, wdata: rd_wdata});
      end
    end
  end

  task automatic m_reset();
    m_q.delete();
    exp_q.delete();
    m_state = 0;
    m_cyc   = '0;
    m_ovf   = 1'b0;
  endtask

  // Model: one clock of behaviour from the current inputs, then compare status outputs.
  task automatic step();
    rec_t r;
    bit   pre_full, do_pop, capture;
    do_pop = 0;
    r.pc = pc; r.inst = inst; r.we = rf_we; r.waddr = rf_waddr; r.wdata = rf_wdata;
    if (clear) begin
      m_q.delete();
      m_state = 0;
      m_cyc   = '0;
      m_ovf   = 1'b0;
    end else begin
      pre_full = (m_q.size() == DEPTH);
      if (rd_req && m_q.size() > 0) begin
        do_pop = 1;
        exp_q.push_back(m_q.pop_front());
      end
      capture = cap_en && (m_state != 2);
      if (capture) begin
        m_cyc   = m_cyc + 1;
        m_state = 1;
        if ((!filt_wb || rf_we) && (mode || !pre_full)) begin
          if (m_q.size() == DEPTH) begin
            m_q.delete(0);
            m_ovf = 1'b1;
          end
          m_q.push_back(r);
        end
        if (m_cyc == LIMIT || (!mode && (pre_full || m_q.size() == DEPTH))) m_state = 2;
      end else if (m_state == 1) begin
        m_state = 0;
      end
    end
    @(posedge clk_in);
    #1;
    chk("rd_vld", 64'(rd_vld), 64'(do_pop));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("empty", 64'(empty), 64'(m_q.size() == 0));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_state == 2));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
  endtask

  task automatic rand_data();
    inst     = $urandom;
    rf_we    = 1'($urandom % 2);
    rf_waddr = 5'($urandom % 32);
    rf_wdata = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_vld"}, 64'(rd_vld), 64'd0);
    chk({tag, "_rd_fields"}, 64'({rd_pc, rd_inst} | 64'({rd_we, rd_waddr, rd_wdata})), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1; cap_en = 0; rd_req = 0;
    step();
    clear = 0;
  endtask

  initial begin
    reset = 0; clear = 0; cap_en = 0; mode = 0; filt_wb = 0; rd_req = 0;
    pc = '0; inst = '0; rf_we = 0; rf_waddr = '0; rf_wdata = '0;
    m_reset();
    #12;
    check_reset_vals("por");
    #10 reset = 1;

    // Ring capture to the cycle limit; the oldest survivor is capture cycle 436.
    mode = 1; filt_wb = 0; cap_en = 1;
    for (int k = 0; k < LIMIT; k++) begin
      pc = 32'h0040_0000 + 32'(4 * k);
      rand_data();
      step();
    end
    chk("A_done", 64'(done), 64'd1);
    chk("A_cycle_cnt", 64'(cycle_cnt), 64'd500);
    chk("A_count", 64'(count), 64'd64);
    chk("A_overflow", 64'(overflow), 64'd1);
    for (int k = 0; k < 3; k++) begin rand_data(); step(); end
    chk("A_cycles_held", 64'(cycle_cnt), 64'd500);
    cap_en = 0; rd_req = 1;
    seen_q.delete();
    for (int k = 0; k < DEPTH + 1; k++) step();
    rd_req = 0;
    chk("A_pops", 64'(seen_q.size()), 64'd64);
    if (seen_q.size() == 64) begin
      chk("A_first_pc", 64'(seen_q[0].pc), 64'h0040_06D0);
      chk("A_last_pc", 64'(seen_q[63].pc), 64'h0040_07CC);
    end
    chk("A_empty", 64'(empty), 64'd1);

    // One-shot fill, then clear out of DONE.
    do_clear();
    mode = 0; cap_en = 1;
    for (int k = 0; k < DEPTH; k++) begin pc = $urandom; rand_data(); step(); end
    chk("B_done", 64'(done), 64'd1);
    chk("B_full", 64'(full), 64'd1);
    chk("B_cycle_cnt", 64'(cycle_cnt), 64'd64);
    chk("B_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < 10; k++) begin pc = $urandom; rand_data(); step(); end
    chk("B_count_held", 64'(count), 64'd64);
    do_clear();
    chk("B_clear_done", 64'(done), 64'd0);
    chk("B_clear_count", 64'(count), 64'd0);

    // Writeback filter: rf_we every third cycle.
    mode = 1; filt_wb = 1; cap_en = 1;
    for (int k = 0; k < 30; k++) begin
      pc = $urandom; rand_data();
      rf_we = (k % 3 == 0);
      if (rf_we) begin rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF; end
      step();
    end
    cap_en = 0; filt_wb = 0;
    chk("C_count", 64'(count), 64'd10);
    chk("C_cycle_cnt", 64'(cycle_cnt), 64'd30);
    seen_q.delete();
    rd_req = 1;
    for (int k = 0; k < 11; k++) step();
    rd_req = 0;
    chk("C_pops", 64'(seen_q.size()), 64'd10);
    foreach (seen_q[i]) begin
      chk("C_we", 64'(seen_q[i].we), 64'd1);
      chk("C_waddr", 64'(seen_q[i].waddr), 64'd5);
      chk("C_wdata", 64'(seen_q[i].wdata), 64'hDEAD_BEEF);
    end

    // Full ring with a same-cycle pop and write.
    do_clear();
    mode = 1; cap_en = 1;
    for (int k = 0; k < DEPTH; k++) begin
      pc = $urandom; rand_data();
      if (k == 0) first_pc = pc;
      step();
    end
    seen_q.delete();
    pc = $urandom; rand_data(); rd_req = 1;
    step();
    chk("D_count", 64'(count), 64'd64);
    chk("D_overflow", 64'(overflow), 64'd0);
    rd_req = 0; cap_en = 0;
    step();
    chk("D_pops", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) chk("D_oldest_pc", 64'(seen_q[0].pc), 64'(first_pc));

    // Pause keeps cycle_cnt; pop while empty is ignored.
    do_clear();
    cap_en = 1;
    for (int k = 0; k < 10; k++) begin pc = $urandom; rand_data(); step(); end
    cap_en = 0;
    for (int k = 0; k < 5; k++) begin pc = $urandom; rand_data(); step(); end
    chk("E_paused_cnt", 64'(cycle_cnt), 64'd10);
    cap_en = 1;
    for (int k = 0; k < 5; k++) begin pc = $urandom; rand_data(); step(); end
    chk("E_resumed_cnt", 64'(cycle_cnt), 64'd15);
    cap_en = 0; rd_req = 1;
    for (int k = 0; k < 17; k++) step();
    chk("E_empty_rd_vld", 64'(rd_vld), 64'd0);
    chk("E_empty_count", 64'(count), 64'd0);
    rd_req = 0;

    // Random traffic across modes, filters, pauses and clears.
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) mode = 1'($urandom % 2);
      if (k % 37 == 0) filt_wb = 1'($urandom % 2);
      cap_en = ($urandom % 8) != 0;
      rd_req = ($urandom % 3) == 0;
      clear  = ($urandom % 150) == 0;
      pc = $urandom; rand_data();
      step();
    end
    clear = 0; rd_req = 0;

    // Asynchronous reset between edges while capturing.
    mode = 1; filt_wb = 0; cap_en = 1;
    for (int k = 0; k < 20; k++) begin pc = $urandom; rand_data(); step(); end
    #3 reset = 0;
    #1 check_reset_vals("arst");
    m_reset();
    cap_en = 0;
    #10 reset = 1;
    for (int k = 0; k < 3; k++) step();
    chk("arst_idle_cnt", 64'(cycle_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
